curve_lut_writer: RTL



---
 rtl/curve_lut_pkg.sv | 16 +
 rtl/curve_lut_clamp.sv | 25 ++
 rtl/curve_lut_writer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/curve_lut_pkg.sv
// Shared types and default geometry for the run-time programmable tone-curve LUT.
// The fixed-ROM variant reuses the same constants and clamp module.
package curve_lut_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int CURVE_WIDTH     = 16;
  localparam int CURVE_DEPTH     = 255;
  localparam int CURVE_ADDR_W    = 8;
  localparam int CURVE_CLAMP_MAX = 1023;

endpackage

// File: rtl/curve_lut_clamp.sv
// Combinational signed clamp of a lookup value to [0, CLAMP_MAX], then saturation
// to the last table address. Shared with the fixed-ROM curve variant.
module curve_lut_clamp
  import curve_lut_pkg::*;
#(
  parameter int WIDTH     = CURVE_WIDTH,
  parameter int DEPTH     = CURVE_DEPTH,
  parameter int ADDR_W    = CURVE_ADDR_W,
  parameter int CLAMP_MAX = CURVE_CLAMP_MAX
) (
  input  logic [WIDTH-1:0]  i_value,
  output logic [ADDR_W-1:0] o_addr
);

  logic signed [31:0] w_ext;
  logic signed [31:0] w_c1;
  logic signed [31:0] w_c2;

  // Work in 32-bit signed so CLAMP_MAX may exceed the WIDTH-bit range.
  assign w_ext  = 32'(signed'(i_value));
  assign w_c1   = (w_ext > CLAMP_MAX) ? CLAMP_MAX : w_ext;
  assign w_c2   = (w_c1 < 0) ? 32'sd0 : w_c1;
  assign o_addr = (w_c2 > (DEPTH - 1)) ? ADDR_W'(DEPTH - 1) : ADDR_W'(w_c2);

endmodule

// File: rtl/curve_lut_writer.sv
// Loadable tone-curve LUT: entries stream in through a valid/ready write port,
// then clamped lookups are served with one cycle of registered latency.
module curve_lut_writer
  import curve_lut_pkg::*;
#(
  parameter int WIDTH     = CURVE_WIDTH,
  parameter int DEPTH     = CURVE_DEPTH,
  parameter int ADDR_W    = CURVE_ADDR_W,
  parameter int CLAMP_MAX = CURVE_CLAMP_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             load_done,
  output logic             table_ready,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [WIDTH-1:0] lk_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output state_t           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready is registered and never depends on the same-cycle valid.

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_wr_ready;
  logic              r_load_done;
  logic              r_table_ready;
  logic              r_lk_ready;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              w_wr_en;
  logic              w_lk_acc;
  logic [ADDR_W-1:0] w_lk_addr;

  // load_start wins over a same-cycle write, so the entry is dropped.
  assign w_wr_en  = ~rst & (r_state == LOAD) & r_wr_ready & wr_valid & ~load_start;
  assign w_lk_acc = lk_valid & r_lk_ready;

  curve_lut_clamp #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .CLAMP_MAX (CLAMP_MAX)
  ) u_clamp (
    .i_value (lk_in),
    .o_addr  (w_lk_addr)
  );

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_wr_ready    <= 1'b0;
      r_load_done   <= 1'b0;
      r_table_ready <= 1'b0;
      r_lk_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_start) begin
            r_state    <= LOAD;
            r_wr_ptr   <= '0;
            r_wr_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            r_wr_ptr <= '0;
          end else if (w_wr_en) begin
            if (r_wr_ptr == ADDR_W'(DEPTH - 1)) begin
              r_state       <= READY;
              r_wr_ptr      <= '0;
              r_wr_ready    <= 1'b0;
              r_load_done   <= 1'b1;
              r_table_ready <= 1'b1;
              r_lk_ready    <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
          end
        end
        READY: begin
          if (load_start) begin
            r_state       <= LOAD;
            r_wr_ptr      <= '0;
            r_wr_ready    <= 1'b1;
            r_table_ready <= 1'b0;
            r_lk_ready    <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_wr_ptr      <= '0;
          r_wr_ready    <= 1'b0;
          r_table_ready <= 1'b0;
          r_lk_ready    <= 1'b0;
        end
      endcase

      // Lookup accepted alongside load_start in READY is still served.
      if (w_lk_acc) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem[w_lk_addr];
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign wr_ready    = r_wr_ready;
  assign load_done   = r_load_done;
  assign table_ready = r_table_ready;
  assign lk_ready    = r_lk_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign dbg_state   = r_state;

endmodule
